switch_debouncer: RTL

- Sits directly downstream of the two-flop switch synchronizer.
- Takes the 16-bit synchronized switch vector and filters contact bounce per bit with a saturating-window counter.
- Produces a debounced switch vector, one-cycle rise/fall pulses, and a valid/ready change-event record that the CPU side consumes (e.g. to trigger a register load or an interrupt).

---
 rtl/switch_debouncer_pkg.sv | 9 +
 rtl/switch_debouncer_bit.sv | 56 +++++
 rtl/switch_debouncer.sv | 65 ++++++
 3 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared sizing and types for the switch debouncer block.
package switch_pkg;

    localparam int NUM_SWITCHES            = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms at 100 MHz

    typedef logic [NUM_SWITCHES-1:0] sw_vec_t;

endpackage

// File: rtl/switch_debouncer_bit.sv
// Single-bit bounce filter: a stable flop plus a window counter that must see
// DEBOUNCE_CYCLES consecutive differing samples before the stable value flips.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic stable_next,
    output logic flip_next
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next state is exposed so the parent can register event data on the
    // same edge that the stable value flips.
    always_comb begin
        stable_next = stable;
        cnt_next    = cnt;
        flip_next   = 1'b0;
        if (sample == stable) begin
            cnt_next = '0;
        end else if (cnt == LAST) begin
            stable_next = sample;
            cnt_next    = '0;
            flip_next   = 1'b1;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= RESET_VALUE;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            stable <= stable_next;
            cnt    <= cnt_next;
            rise   <= flip_next & stable_next;
            fall   <= flip_next & ~stable_next;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Per-bit switch debouncing with edge pulses and an accumulating change-event
// record handed to the CPU side over a valid/ready handshake.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int                 NUM_SW          = NUM_SWITCHES,
    parameter int                 DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int                 CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic [NUM_SW-1:0]  RESET_VALUE     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sync_in,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              change_valid,
    output logic [NUM_SW-1:0] change_mask,
    output logic [NUM_SW-1:0] change_value,
    input  logic              change_ready
);

    logic [NUM_SW-1:0] stable_next;
    logic [NUM_SW-1:0] flip_next;
    logic              accepted;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_bit (
            .clk         (clk),
            .rst_n       (rst_n),
            .sample      (sync_in[i]),
            .stable      (sw_stable[i]),
            .rise        (sw_rise[i]),
            .fall        (sw_fall[i]),
            .stable_next (stable_next[i]),
            .flip_next   (flip_next[i])
        );
    end

    // Handshake: an event transfers on any edge where change_valid && change_ready.
    // change_valid never drops without a transfer; mask/value only move while
    // valid is high and ready low when new changes merge in. A change landing
    // on the transfer edge starts a fresh mask so nothing is lost or repeated.
    assign accepted = change_valid && change_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_valid <= 1'b0;
            change_mask  <= '0;
            change_value <= RESET_VALUE;
        end else if (flip_next != '0) begin
            change_valid <= 1'b1;
            change_mask  <= (accepted ? '0 : change_mask) | flip_next;
            change_value <= stable_next;
        end else if (accepted) begin
            change_valid <= 1'b0;
            change_mask  <= '0;
        end
    end

endmodule
